// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the core fetch PC and reset, with run/halt control, stall watchdog and run-cycle counter.
module pc_sequencer #(
  parameter int unsigned                  DATA_WIDTH   = 64,
  parameter logic [DATA_WIDTH-1:0]        RESET_VECTOR = 'h8000_0000,
  parameter int unsigned                  RST_CYCLES   = 2,
  parameter int unsigned                  STALL_LIMIT  = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  run_i,
  input  logic                  halt_req_i,
  input  logic [DATA_WIDTH-1:0] resume_pc_i,
  input  logic [DATA_WIDTH-1:0] new_pc_i,
  input  logic [7:0]            exceptions_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  core_rst_o,
  output logic                  halted_o,
  output logic [2:0]            halt_cause_o,
  output logic [DATA_WIDTH-1:0] halt_pc_o,
  output logic [63:0]           cycle_cnt_o
);
  localparam int unsigned RCW = $clog2(RST_CYCLES + 1);
  localparam int unsigned WDW = $clog2(STALL_LIMIT + 1);
  localparam logic [RCW-1:0] RC_MAX = RCW'(RST_CYCLES - 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(STALL_LIMIT - 1);
  typedef enum logic [2:0] {S_RESET, S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_e;
  state_e                state_q, state_d;
  logic [RCW-1:0]        rst_cnt_q, rst_cnt_d;
  logic [WDW-1:0]        wd_cnt_q, wd_cnt_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d, halt_pc_q, halt_pc_d;
  logic                  core_rst_q, core_rst_d, halted_q, halted_d;
  logic [2:0]            cause_q, cause_d, code;
  logic [63:0]           cyc_q, cyc_d;
  logic                  stall, wd_evt, evt, run_st, unused_exc;
  assign unused_exc = ^exceptions_i[7:5];
  assign run_st = state_q == S_RUN;
  assign stall  = new_pc_i == pc_q;
  assign wd_evt = stall && wd_cnt_q == WD_MAX;
  // Lowest exception bit wins, then watchdog, then the external request.
  assign code = exceptions_i[0] ? 3'd1 : exceptions_i[1] ? 3'd2 : exceptions_i[2] ? 3'd3 :
                exceptions_i[3] ? 3'd4 : exceptions_i[4] ? 3'd5 : wd_evt ? 3'd6 :
                halt_req_i ? 3'd7 : 3'd0;
  assign evt = code != 3'd0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_RESET;
      rst_cnt_q  <= '0;
      wd_cnt_q   <= '0;
      pc_q       <= RESET_VECTOR;
      halt_pc_q  <= '0;
      core_rst_q <= 1'b1;
      halted_q   <= 1'b0;
      cause_q    <= '0;
      cyc_q      <= '0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      pc_q       <= pc_d;
      halt_pc_q  <= halt_pc_d;
      core_rst_q <= core_rst_d;
      halted_q   <= halted_d;
      cause_q    <= cause_d;
      cyc_q      <= cyc_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = (rst_cnt_q == RC_MAX) ? S_IDLE : S_RESET;
      S_IDLE:   state_d = run_i ? S_RUN : S_IDLE;
      S_RUN:    state_d = evt ? S_DRAIN : S_RUN;
      S_DRAIN:  state_d = S_HALTED;
      S_HALTED: state_d = run_i ? S_RUN : S_HALTED;
      default:  state_d = S_RESET;
    endcase
  end
  always_comb begin
    rst_cnt_d  = (state_q == S_RESET) ? rst_cnt_q + 1'b1 : '0;
    wd_cnt_d   = (run_st && stall) ? wd_cnt_q + 1'b1 : '0;
    pc_d       = (state_q == S_IDLE) ? RESET_VECTOR :
                 run_st ? (evt ? pc_q : new_pc_i) :
                 (state_q == S_HALTED) ? (run_i ? resume_pc_i : halt_pc_q) : pc_q;
    core_rst_d = state_d != S_RUN;
    halted_d   = state_d == S_HALTED;
    cause_d    = (run_st && evt) ? code : (state_q == S_HALTED && run_i) ? 3'd0 : cause_q;
    halt_pc_d  = (run_st && evt) ? pc_q : halt_pc_q;
    cyc_d      = run_st ? cyc_q + 64'd1 : cyc_q;
  end
  assign pc_o         = pc_q;
  assign core_rst_o   = core_rst_q;
  assign halted_o     = halted_q;
  assign halt_cause_o = cause_q;
  assign halt_pc_o    = halt_pc_q;
  assign cycle_cnt_o  = cyc_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table plus hand-written reset sequences for pc_sequencer.
module tb_pc_sequencer;
  localparam logic [63:0] A = 64'h8000_0000;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0, hreq = 1'b0;
  logic [63:0] rpc = '0, npc = '0;
  logic [7:0]  exc = '0;
  logic [63:0] pc, hpc, cyc;
  logic        core_rst, halted;
  logic [2:0]  cause;
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  pc_sequencer #(.DATA_WIDTH(64), .RESET_VECTOR(A), .RST_CYCLES(2), .STALL_LIMIT(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .run_i(run), .halt_req_i(hreq), .resume_pc_i(rpc),
    .new_pc_i(npc), .exceptions_i(exc), .pc_o(pc), .core_rst_o(core_rst), .halted_o(halted),
    .halt_cause_o(cause), .halt_pc_o(hpc), .cycle_cnt_o(cyc)
  );
  typedef struct {
    logic run, hreq;
    logic [7:0] exc;
    logic [63:0] npc, rpc, e_pc;
    logic e_rst, e_hlt;
    logic [2:0] e_cause;
    logic [63:0] e_hpc, e_cyc;
  } vec_t;
  vec_t v[$];
  function automatic vec_t mk(logic r, logic h, logic [7:0] x, logic [63:0] n, logic [63:0] rp,
                              logic [63:0] epc, logic er, logic eh, logic [2:0] ec,
                              logic [63:0] ehpc, logic [63:0] ecyc);
    vec_t t;
    t.run = r; t.hreq = h; t.exc = x; t.npc = n; t.rpc = rp; t.e_pc = epc;
    t.e_rst = er; t.e_hlt = eh; t.e_cause = ec; t.e_hpc = ehpc; t.e_cyc = ecyc;
    return t;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk_all(input string nm, input logic [63:0] epc, input logic er, input logic eh,
                         input logic [2:0] ec, input logic [63:0] ehpc, input logic [63:0] ecyc);
    chk({nm, " pc"}, pc, epc);
    chk({nm, " core_rst"}, 64'(core_rst), 64'(er));
    chk({nm, " halted"}, 64'(halted), 64'(eh));
    chk({nm, " cause"}, 64'(cause), 64'(ec));
    chk({nm, " halt_pc"}, hpc, ehpc);
    chk({nm, " cycles"}, cyc, ecyc);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    //      run h  exc    new_pc     resume     pc         rst hlt cause halt_pc   cyc
    v.push_back(mk(1, 0, 8'h00, A,         0,         A,         0, 0, 0, 0,         0));
    v.push_back(mk(1, 0, 8'h00, A+64'h04,  0,         A+64'h04,  0, 0, 0, 0,         1));
    v.push_back(mk(1, 0, 8'h00, A+64'h08,  0,         A+64'h08,  0, 0, 0, 0,         2));
    v.push_back(mk(1, 0, 8'h00, A+64'h0C,  0,         A+64'h0C,  0, 0, 0, 0,         3));
    v.push_back(mk(1, 0, 8'h00, A+64'h10,  0,         A+64'h10,  0, 0, 0, 0,         4));
    v.push_back(mk(1, 0, 8'h10, A+64'h14,  0,         A+64'h10,  1, 0, 5, A+64'h10,  5));
    v.push_back(mk(0, 0, 8'h00, A+64'h14,  0,         A+64'h10,  1, 1, 5, A+64'h10,  5));
    v.push_back(mk(0, 0, 8'h00, A+64'h14,  0,         A+64'h10,  1, 1, 5, A+64'h10,  5));
    v.push_back(mk(1, 0, 8'h00, A+64'h14,  A+64'h40,  A+64'h40,  0, 0, 0, A+64'h10,  5));
    v.push_back(mk(1, 1, 8'h0C, A+64'h44,  0,         A+64'h40,  1, 0, 3, A+64'h40,  6));
    v.push_back(mk(1, 0, 8'h00, A+64'h44,  0,         A+64'h40,  1, 1, 3, A+64'h40,  6));
    v.push_back(mk(1, 0, 8'h00, A+64'h44,  A+64'h80,  A+64'h80,  0, 0, 0, A+64'h40,  6));
    v.push_back(mk(1, 0, 8'h00, A+64'h80,  0,         A+64'h80,  0, 0, 0, A+64'h40,  7));
    v.push_back(mk(1, 0, 8'h00, A+64'h80,  0,         A+64'h80,  0, 0, 0, A+64'h40,  8));
    v.push_back(mk(1, 0, 8'h00, A+64'h80,  0,         A+64'h80,  0, 0, 0, A+64'h40,  9));
    v.push_back(mk(1, 0, 8'h00, A+64'h84,  0,         A+64'h84,  0, 0, 0, A+64'h40,  10));
    v.push_back(mk(1, 0, 8'h00, A+64'h84,  0,         A+64'h84,  0, 0, 0, A+64'h40,  11));
    v.push_back(mk(1, 0, 8'h00, A+64'h84,  0,         A+64'h84,  0, 0, 0, A+64'h40,  12));
    v.push_back(mk(1, 0, 8'h00, A+64'h84,  0,         A+64'h84,  0, 0, 0, A+64'h40,  13));
    v.push_back(mk(1, 0, 8'h00, A+64'h84,  0,         A+64'h84,  1, 0, 6, A+64'h84,  14));
    v.push_back(mk(0, 0, 8'h00, A+64'h84,  0,         A+64'h84,  1, 1, 6, A+64'h84,  14));
    v.push_back(mk(1, 0, 8'h00, A+64'h84,  A+64'h100, A+64'h100, 0, 0, 0, A+64'h84,  14));
    v.push_back(mk(1, 1, 8'hE0, A+64'h104, 0,         A+64'h100, 1, 0, 7, A+64'h100, 15));
    v.push_back(mk(1, 0, 8'h00, A+64'h104, 0,         A+64'h100, 1, 1, 7, A+64'h100, 15));
    v.push_back(mk(1, 0, 8'h00, A+64'h104, A+64'h100, A+64'h100, 0, 0, 0, A+64'h100, 15));
    v.push_back(mk(1, 0, 8'h00, A+64'h104, 0,         A+64'h104, 0, 0, 0, A+64'h100, 16));
    v.push_back(mk(1, 0, 8'h11, A+64'h108, 0,         A+64'h104, 1, 0, 1, A+64'h104, 17));
    v.push_back(mk(0, 0, 8'h00, A+64'h108, 0,         A+64'h104, 1, 1, 1, A+64'h104, 17));
    v.push_back(mk(1, 0, 8'h00, A+64'h108, A+64'h200, A+64'h200, 0, 0, 0, A+64'h104, 17));
    repeat (3) tick();
    chk_all("reset", A, 1, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick(); chk("rst_hold1 core_rst", 64'(core_rst), 64'd1);
    tick(); chk("rst_hold2 core_rst", 64'(core_rst), 64'd1);
    tick(); chk_all("idle", A, 1, 0, 0, 0, 0);
    foreach (v[i]) begin
      run = v[i].run; hreq = v[i].hreq; exc = v[i].exc; npc = v[i].npc; rpc = v[i].rpc;
      tick();
      chk_all($sformatf("row%0d", i), v[i].e_pc, v[i].e_rst, v[i].e_hlt, v[i].e_cause,
              v[i].e_hpc, v[i].e_cyc);
    end
    npc = A + 64'h204; run = 1'b0; rpc = '0; exc = '0; hreq = 1'b0;
    tick();
    chk_all("prereset", A + 64'h204, 0, 0, 0, A + 64'h104, 18);
    #2 rst_n = 1'b0;
    #1 chk_all("async_reset", A, 1, 0, 0, 0, 0);
    run = 1'b1;
    tick();
    rst_n = 1'b1;
    tick(); chk("rerun1 core_rst", 64'(core_rst), 64'd1);
    tick(); chk("rerun2 core_rst", 64'(core_rst), 64'd1);
    tick(); chk_all("rerun_run", A, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
